bcd_scan_ctrl: RTL and testbench

- Sequencer that sanitises a wide packed BCD word, LANES digits per cycle, instead of one flat 300-digit combinational check.
- Accepts one word per valid/ready transaction and replaces every invalid digit (value > 9) with 0.
- Counts the invalid digits, records the lowest invalid digit index, and presents the result through an output valid/ready handshake.
- Sits between the BCD capture logic and the decimal display/consumer path.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_lane_check.sv | 38 +++
 rtl/bcd_scan_ctrl.sv | 116 +++++++++++
 tb/tb_bcd_scan_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD scan sequencer.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_bad(input digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_lane_check.sv
// Combinational check of LANES packed BCD digits: sanitised digits, invalid mask,
// invalid count and lowest invalid lane.
module bcd_lane_check
    import bcd_pkg::*;
#(
    parameter  int unsigned LANES = 4,
    localparam int unsigned CNT_W = $clog2(LANES + 1),
    localparam int unsigned SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [4*LANES-1:0] i_dig,
    output logic [4*LANES-1:0] o_dig,
    output logic [LANES-1:0]   o_bad_mask,
    output logic [CNT_W-1:0]   o_bad_cnt,
    output logic [SEL_W-1:0]   o_first,
    output logic               o_any
);

    always_comb begin
        o_dig      = i_dig;
        o_bad_mask = '0;
        o_bad_cnt  = '0;
        o_first    = '0;
        o_any      = 1'b0;
        // Ascending scan; the first hit fixes the lowest invalid lane.
        for (int k = 0; k < int'(LANES); k++) begin
            if (digit_bad(i_dig[4*k +: 4])) begin
                o_dig[4*k +: 4] = 4'd0;
                o_bad_mask[k]   = 1'b1;
                o_bad_cnt       = o_bad_cnt + CNT_W'(1);
                if (!o_any) begin
                    o_first = SEL_W'(k);
                end
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Sequencer that sanitises a wide packed BCD word LANES digits per cycle and
// reports the invalid-digit count and the lowest invalid digit index.
module bcd_scan_ctrl
    import bcd_pkg::*;
#(
    parameter  int unsigned NDIG  = 300,
    parameter  int unsigned LANES = 4,
    localparam int unsigned CNT_W = $clog2(NDIG + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*NDIG-1:0]   in_bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   out_dec,
    output logic [CNT_W-1:0]    out_err_cnt,
    output logic [CNT_W-1:0]    out_first_err,
    output logic                busy
);

    localparam int unsigned LC_W   = $clog2(LANES + 1);
    localparam int unsigned SEL_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned BASE_W = CNT_W + 2;

    state_t             r_state;
    logic [4*NDIG-1:0]  r_buf;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_first_err;

    logic [BASE_W-1:0]  w_base;
    logic [4*LANES-1:0] w_lane_in;
    logic [4*LANES-1:0] w_lane_out;
    logic [LANES-1:0]   w_bad_mask;
    logic [LC_W-1:0]    w_bad_cnt;
    logic [SEL_W-1:0]   w_first;
    logic               w_any;
    logic               w_last;

    // Bit offset of the current digit group; 4*idx always fits CNT_W+2 bits.
    assign w_base    = {r_idx, 2'b00};
    assign w_lane_in = r_buf[w_base +: 4*LANES];
    assign w_last    = (r_idx == CNT_W'(NDIG - LANES));

    bcd_lane_check #(
        .LANES      (LANES)
    ) u_lane_check (
        .i_dig      (w_lane_in),
        .o_dig      (w_lane_out),
        .o_bad_mask (w_bad_mask),
        .o_bad_cnt  (w_bad_cnt),
        .o_first    (w_first),
        .o_any      (w_any)
    );

    assign in_ready      = (r_state == IDLE) && !abort && !reset;
    assign out_valid     = (r_state == DONE);
    assign busy          = (r_state != IDLE);
    assign out_dec       = r_buf;
    assign out_err_cnt   = r_err_cnt;
    assign out_first_err = r_first_err;

    // Abort wins over everything except reset, and keeps the partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_idx       <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else if (abort) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_buf       <= in_bcd;
                        r_idx       <= '0;
                        r_err_cnt   <= '0;
                        r_first_err <= CNT_W'(NDIG);
                        r_state     <= SCAN;
                    end
                end
                SCAN: begin
                    r_buf[w_base +: 4*LANES] <= w_lane_out;
                    r_err_cnt <= r_err_cnt + CNT_W'(w_bad_cnt);
                    if ((r_first_err == CNT_W'(NDIG)) && w_any) begin
                        r_first_err <= r_idx + CNT_W'(w_first);
                    end
                    r_idx <= r_idx + CNT_W'(LANES);
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Lane summary outputs must agree with the invalid mask.
    always_comb begin
        if (r_state == SCAN) begin
            a_any_mask: assert (w_any == (|w_bad_mask));
            a_cnt_mask: assert (int'(w_bad_cnt) == $countones(w_bad_mask));
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl: stimulus pushes model results, a monitor
// compares them whenever the DUT presents a result.
module tb_bcd_scan_ctrl;

    localparam int NDIG  = 300;
    localparam int LANES = 4;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int NSCAN = NDIG / LANES;

    typedef struct {
        logic [4*NDIG-1:0] e_dec;
        int                e_cnt;
        int                e_first;
        int                e_acc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] in_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [4*NDIG-1:0] out_dec;
    logic [CNT_W-1:0]  out_err_cnt;
    logic [CNT_W-1:0]  out_first_err;
    logic              busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   prev_valid = 1'b0;
    exp_t q[$];

    bcd_scan_ctrl #(
        .NDIG          (NDIG),
        .LANES         (LANES)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_bcd        (in_bcd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_dec       (out_dec),
        .out_err_cnt   (out_err_cnt),
        .out_first_err (out_first_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_dec(input string nm, input logic [4*NDIG-1:0] act,
                           input logic [4*NDIG-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            for (int i = 0; i < NDIG; i++) begin
                if (act[4*i +: 4] !== req[4*i +: 4]) begin
                    $display("FAIL %s digit %0d actual=%h required=%h (cycle %0d)",
                             nm, i, act[4*i +: 4], req[4*i +: 4], cyc);
                    break;
                end
            end
        end
    endtask

    // Reference: every digit above nine becomes zero and is counted.
    function automatic exp_t model(input logic [4*NDIG-1:0] w);
        exp_t e;
        logic [3:0] d;
        e.e_dec   = w;
        e.e_cnt   = 0;
        e.e_first = NDIG;
        e.e_acc   = 0;
        for (int i = 0; i < NDIG; i++) begin
            d = w[4*i +: 4];
            if (d > 4'd9) begin
                e.e_dec[4*i +: 4] = 4'd0;
                e.e_cnt++;
                if (e.e_first == NDIG) e.e_first = i;
            end
        end
        return e;
    endfunction

    function automatic logic [4*NDIG-1:0] fill(input logic [3:0] d);
        logic [4*NDIG-1:0] w;
        for (int i = 0; i < NDIG; i++) w[4*i +: 4] = d;
        return w;
    endfunction

    function automatic logic [4*NDIG-1:0] rand_word(input int bad_pct);
        logic [4*NDIG-1:0] w;
        for (int i = 0; i < NDIG; i++) begin
            if (int'($urandom_range(0, 99)) < bad_pct) w[4*i +: 4] = 4'($urandom_range(10, 15));
            else                                       w[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    // Monitor: compare whenever a result is presented; pop on handshake.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                chk("out_valid_unexpected", int'(out_valid), 0);
            end else begin
                if (!prev_valid) chk("latency", cyc - q[0].e_acc, NSCAN);
                chk_dec("out_dec", out_dec, q[0].e_dec);
                chk("out_err_cnt", int'(out_err_cnt), q[0].e_cnt);
                chk("out_first_err", int'(out_first_err), q[0].e_first);
                chk("in_ready_in_done", int'(in_ready), 0);
                chk("busy_in_done", int'(busy), 1);
                if (out_ready && !abort) void'(q.pop_front());
            end
        end
        prev_valid = out_valid && !reset;
    end

    task automatic send(input logic [4*NDIG-1:0] w, input bit push);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_bcd   = w;
        in_valid = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", int'(in_ready), 1);
        if (ok && push) begin
            e       = model(w);
            e.e_acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bcd   = rand_word(50);
    endtask

    task automatic receive(input int hold);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("out_valid_timeout", int'(out_valid), 1);
        repeat (hold) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after_hs", int'(in_ready), 1);
        chk("out_valid_after_hs", int'(out_valid), 0);
    endtask

    initial begin
        logic [4*NDIG-1:0] w;
        int n_bad;
        int first;
        reset     = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bcd    = '0;

        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_err_cnt", int'(out_err_cnt), 0);
        chk("post_rst_first_err", int'(out_first_err), 0);
        chk_dec("post_rst_dec", out_dec, '0);

        // All valid digits.
        send(fill(4'h5), 1'b1);
        receive(0);

        // Mixed low digits 9,A,3,F,0,C,9,1 (digit7..digit0) over a field of fives.
        w = fill(4'h5);
        w[31:0] = 32'h9A3F0C91;
        send(w, 1'b1);
        receive(0);

        // Result held under back-pressure.
        send(rand_word(20), 1'b1);
        receive(5);

        // Abort on the second SCAN cycle; only the first digit group was scanned.
        w = fill(4'h2);
        w[7:4]   = 4'hB;
        w[43:40] = 4'hE;
        n_bad = 0;
        first = NDIG;
        for (int i = 0; i < LANES; i++) begin
            if (w[4*i +: 4] > 4'd9) begin
                n_bad++;
                if (first == NDIG) first = i;
            end
        end
        send(w, 1'b0);
        @(posedge clk); #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", int'(busy), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_partial_cnt", int'(out_err_cnt), n_bad);
        chk("abort_partial_first", int'(out_first_err), first);

        // Abort in IDLE blocks a simultaneous offer.
        @(posedge clk); #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("abort_idle_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);

        // Next word after abort starts counts from zero.
        send(rand_word(30), 1'b1);
        receive(1);

        // Reset in DONE with an offer pending; the offer is taken right after reset.
        send(rand_word(40), 1'b1);
        for (int t = 0; t < 400 && !out_valid; t++) @(negedge clk);
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        w        = rand_word(25);
        in_bcd   = w;
        q.delete();
        @(negedge clk);
        chk("rst_done_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_done_out_valid", int'(out_valid), 0);
        chk("rst_done_busy", int'(busy), 0);
        chk("rst_done_err_cnt", int'(out_err_cnt), 0);
        chk("rst_done_first_err", int'(out_first_err), 0);
        chk_dec("rst_done_dec", out_dec, '0);
        chk("rst_done_in_ready_after", int'(in_ready), 1);
        begin
            exp_t e;
            e       = model(w);
            e.e_acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_done_accepted", int'(busy), 1);
        receive(0);

        // Boundaries: all invalid, all nine, all zero, only the last digit invalid.
        send(fill(4'hF), 1'b1);
        receive(0);
        send(fill(4'h9), 1'b1);
        receive(0);
        send(fill(4'h0), 1'b1);
        receive(2);
        w = fill(4'h9);
        w[4*NDIG-1 -: 4] = 4'hA;
        send(w, 1'b1);
        receive(0);

        for (int n = 0; n < 14; n++) begin
            send(rand_word(int'($urandom_range(0, 100))), 1'b1);
            receive(int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
